// File: rtl/pc_seq_ctrl.sv
// Fetch sequencer: program counter with priority jumps, IDLE/RUN/DONE run handshake,
// registered ALU flags and a saturating RUN-cycle counter. All outputs are registered.
module pc_seq_ctrl #(
    parameter int D        = 12,
    parameter int RW       = 8,
    parameter int END_ADDR = 319,
    parameter int CW       = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          stall,
    input  logic          absjump_en,
    input  logic          regjump_en,
    input  logic          reljump_en,
    input  logic [D-1:0]  target,
    input  logic [RW-1:0] inB,
    input  logic          zero_i,
    input  logic          pari_i,
    input  logic          sc_o,
    input  logic          flag_en,
    input  logic          sc_clr,
    input  logic          sc_en,
    output logic [D-1:0]  prog_ctr,
    output logic          running,
    output logic          done,
    output logic          zeroQ,
    output logic          pariQ,
    output logic          sc_in,
    output logic [CW-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widen inB to whichever is larger so one slice covers truncation and zero-extension.
    localparam int XW = (RW > D) ? RW : D;
    localparam logic [D-1:0] END_PC = D'(END_ADDR);

    state_t         state;
    logic [XW-1:0]  inb_ext;
    logic [D-1:0]   reg_target;
    logic [D-1:0]   next_pc;

    assign inb_ext    = XW'(inB);
    assign reg_target = inb_ext[D-1:0];

    always_comb begin
        next_pc = prog_ctr + D'(1);
        if (absjump_en)
            next_pc = target;
        else if (regjump_en)
            next_pc = reg_target;
        else if (reljump_en)
            next_pc = prog_ctr + target;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            prog_ctr  <= '0;
            cycle_cnt <= '0;
            zeroQ     <= 1'b0;
            pariQ     <= 1'b0;
            sc_in     <= 1'b0;
            running   <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (req) begin
                        state     <= RUN;
                        running   <= 1'b1;
                        done      <= 1'b0;
                        prog_ctr  <= '0;
                        cycle_cnt <= '0;
                        zeroQ     <= 1'b0;
                        pariQ     <= 1'b0;
                        sc_in     <= 1'b0;
                    end
                end
                RUN: begin
                    if (cycle_cnt != '1)
                        cycle_cnt <= cycle_cnt + CW'(1);
                    // Halt beats stall; the PC freezes at the address that ended the run.
                    if (prog_ctr >= END_PC) begin
                        state   <= DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else if (!stall) begin
                        prog_ctr <= next_pc;
                    end
                    if (!stall) begin
                        if (flag_en) begin
                            zeroQ <= zero_i;
                            pariQ <= pari_i;
                        end
                        if (sc_clr)
                            sc_in <= 1'b0;
                        else if (sc_en)
                            sc_in <= sc_o;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: directed vector table, hand-written corner sequences,
// then random stimulus checked against an integer-arithmetic reference model.
module tb_pc_seq_ctrl;

    localparam int D = 12, RW = 8, END_ADDR = 319, CW = 16;
    localparam int PC_MOD = 1 << D;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset, req, stall, absjump_en, regjump_en, reljump_en;
    logic [D-1:0]  target;
    logic [RW-1:0] inB;
    logic          zero_i, pari_i, sc_o, flag_en, sc_clr, sc_en;
    logic [D-1:0]  prog_ctr;
    logic          running, done, zeroQ, pariQ, sc_in;
    logic [CW-1:0] cycle_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_seq_ctrl #(.D(D), .RW(RW), .END_ADDR(END_ADDR), .CW(CW)) dut (
        .clk(clk), .reset(reset), .req(req), .stall(stall),
        .absjump_en(absjump_en), .regjump_en(regjump_en), .reljump_en(reljump_en),
        .target(target), .inB(inB), .zero_i(zero_i), .pari_i(pari_i), .sc_o(sc_o),
        .flag_en(flag_en), .sc_clr(sc_clr), .sc_en(sc_en),
        .prog_ctr(prog_ctr), .running(running), .done(done),
        .zeroQ(zeroQ), .pariQ(pariQ), .sc_in(sc_in), .cycle_cnt(cycle_cnt)
    );

    typedef struct {
        logic        req, stall, abs_j, reg_j, rel_j;
        logic [11:0] tgt;
        logic [7:0]  inb;
        logic [11:0] e_pc;
        logic        e_run, e_done;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic rq, st, a, g, r, input logic [11:0] t,
                                input logic [7:0] b, input logic [11:0] pc,
                                input logic ru, dn, input logic [15:0] c);
        vec_t v;
        v.req = rq; v.stall = st; v.abs_j = a; v.reg_j = g; v.rel_j = r;
        v.tgt = t; v.inb = b; v.e_pc = pc; v.e_run = ru; v.e_done = dn; v.e_cnt = c;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req = 0; stall = 0; absjump_en = 0; regjump_en = 0; reljump_en = 0;
        target = '0; inB = '0; zero_i = 0; pari_i = 0; sc_o = 0;
        flag_en = 0; sc_clr = 0; sc_en = 0;
    endtask

    // Reference model: state as plain ints (0 idle, 1 run, 2 done), PC via modulo arithmetic.
    int m_st, m_pc, m_cnt, m_z, m_p, m_sc;

    task automatic model_edge();
        if (reset) begin
            m_st = 0; m_pc = 0; m_cnt = 0; m_z = 0; m_p = 0; m_sc = 0;
        end else if (m_st != 1) begin
            if (req) begin
                m_st = 1; m_pc = 0; m_cnt = 0; m_z = 0; m_p = 0; m_sc = 0;
            end
        end else begin
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            if (m_pc >= END_ADDR) m_st = 2;
            else if (!stall) begin
                if (absjump_en)      m_pc = int'(target);
                else if (regjump_en) m_pc = int'(inB) % PC_MOD;
                else if (reljump_en) m_pc = (m_pc + int'(target)) % PC_MOD;
                else                 m_pc = (m_pc + 1) % PC_MOD;
            end
            if (!stall) begin
                if (flag_en) begin m_z = zero_i; m_p = pari_i; end
                if (sc_clr) m_sc = 0;
                else if (sc_en) m_sc = sc_o;
            end
        end
    endtask

    task automatic check_flags(input string name, input logic z, p, s);
        check(name, {61'd0, zeroQ, pariQ, sc_in}, {61'd0, z, p, s});
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        tick(); tick();
        check("reset_pc", prog_ctr, 0);
        check("reset_run_done", {running, done}, 2'b00);
        check("reset_cnt", cycle_cnt, 0);
        check_flags("reset_flags", 0, 0, 0);
        reset = 0;
        tick();
        check("idle_no_req", {running, done, prog_ctr}, 0);

        // Directed table: one row per clock edge.
        vt.push_back(mk(1,0,0,0,0,12'h000,8'd0,  12'd0,1,0,16'd0));
        for (int i = 1; i <= 5; i++)
            vt.push_back(mk(0,0,0,0,0,12'h000,8'd0,12'(i),1,0,16'(i)));
        vt.push_back(mk(0,0,0,0,1,12'hFFE,8'd0,  12'd3,  1,0,16'd6));
        vt.push_back(mk(0,0,0,1,0,12'h000,8'd40, 12'd40, 1,0,16'd7));
        vt.push_back(mk(0,0,1,1,1,12'd100,8'd40, 12'd100,1,0,16'd8));
        vt.push_back(mk(0,0,1,0,0,12'd318,8'd0,  12'd318,1,0,16'd9));
        vt.push_back(mk(0,0,0,0,0,12'd0,  8'd0,  12'd319,1,0,16'd10));
        vt.push_back(mk(0,0,0,0,0,12'd0,  8'd0,  12'd319,0,1,16'd11));
        vt.push_back(mk(0,0,0,0,0,12'd0,  8'd0,  12'd319,0,1,16'd11));
        vt.push_back(mk(1,0,0,0,0,12'd0,  8'd0,  12'd0,  1,0,16'd0));
        vt.push_back(mk(0,0,0,0,0,12'd0,  8'd0,  12'd1,  1,0,16'd1));
        vt.push_back(mk(0,0,0,0,0,12'd0,  8'd0,  12'd2,  1,0,16'd2));
        vt.push_back(mk(0,0,0,0,1,12'hFFD,8'd0,  12'd4095,1,0,16'd3));
        vt.push_back(mk(0,0,0,0,0,12'd0,  8'd0,  12'd4095,0,1,16'd4));
        vt.push_back(mk(1,0,0,0,0,12'd0,  8'd0,  12'd0,  1,0,16'd0));
        foreach (vt[i]) begin
            req = vt[i].req; stall = vt[i].stall;
            absjump_en = vt[i].abs_j; regjump_en = vt[i].reg_j; reljump_en = vt[i].rel_j;
            target = vt[i].tgt; inB = vt[i].inb;
            tick();
            check($sformatf("vec%0d", i), {prog_ctr, running, done, cycle_cnt},
                  {vt[i].e_pc, vt[i].e_run, vt[i].e_done, vt[i].e_cnt});
        end
        idle_inputs();

        // Flags, then stall holding PC/flags/jump while the counter keeps going.
        flag_en = 1; zero_i = 1; pari_i = 1; sc_en = 1; sc_o = 1;
        tick();
        check_flags("flags_load", 1, 1, 1);
        stall = 1; reljump_en = 1; target = 12'd5; zero_i = 0; pari_i = 0; sc_o = 0;
        tick(); tick(); tick();
        check("stall_pc", prog_ctr, 1);
        check("stall_cnt", cycle_cnt, 4);
        check_flags("stall_flags", 1, 1, 1);
        stall = 0; reljump_en = 0; flag_en = 0; sc_clr = 1; sc_en = 1; sc_o = 1;
        tick();
        check_flags("sc_clr_wins", 1, 1, 0);
        check("after_stall_pc", prog_ctr, 2);
        idle_inputs();

        // A jump past the halt address ends the run even while stalled.
        absjump_en = 1; target = 12'd400;
        tick();
        check("jump_past_end", {prog_ctr, running, done}, {12'd400, 2'b10});
        absjump_en = 0; stall = 1;
        tick();
        check("halt_over_stall", {prog_ctr, running, done}, {12'd400, 2'b01});
        stall = 0;

        // Synchronous reset mid-run; req is ignored while reset is high.
        req = 1; tick(); req = 0;
        absjump_en = 1; target = 12'd50; tick(); absjump_en = 0;
        check("at_pc50", prog_ctr, 50);
        reset = 1; req = 1;
        tick();
        check("midrun_reset", {prog_ctr, running, done, cycle_cnt, zeroQ, pariQ, sc_in}, 0);
        tick();
        check("req_during_reset", {running, done}, 2'b00);
        reset = 0; req = 0;
        tick();
        check("idle_after_reset", {running, done}, 2'b00);

        // Counter saturation: stall from PC 0 so the run never reaches the halt address.
        req = 1; tick(); req = 0; stall = 1;
        repeat (CNT_MAX) tick();
        check("cnt_reaches_max", cycle_cnt, CNT_MAX);
        tick();
        check("cnt_saturates", {cycle_cnt, prog_ctr, running}, {16'hFFFF, 12'd0, 1'b1});
        stall = 0;

        // Random stimulus against the reference model.
        reset = 1; model_edge(); tick(); reset = 0;
        for (int i = 0; i < 4000; i++) begin
            reset      = ($urandom_range(299) == 0);
            req        = ($urandom_range(7) == 0);
            stall      = ($urandom_range(5) == 0);
            absjump_en = ($urandom_range(39) == 0);
            regjump_en = ($urandom_range(29) == 0);
            reljump_en = ($urandom_range(19) == 0);
            target     = D'($urandom);
            inB        = RW'($urandom);
            zero_i = $urandom_range(1); pari_i = $urandom_range(1); sc_o = $urandom_range(1);
            flag_en = $urandom_range(1); sc_clr = ($urandom_range(3) == 0); sc_en = $urandom_range(1);
            model_edge();
            tick();
            check($sformatf("rand%0d", i),
                  {prog_ctr, running, done, zeroQ, pariQ, sc_in, cycle_cnt},
                  {12'(m_pc), m_st == 1, m_st == 2, 1'(m_z), 1'(m_p), 1'(m_sc), 16'(m_cnt)});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
